// File: rtl/up_counter_ctrl_pkg.sv
// Shared types and constants for the up-counter sequencing controller.
// State encodings are fixed so that they read the same in waveforms and in other blocks.
package up_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      RUN  = 2'b10,
      DONE = 2'b11
   } state_e;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   localparam int PERIOD_CNT_W = 8;

endpackage

// File: rtl/up_counter_ctrl_if.sv
// Command/status bundle of up_counter_ctrl. The master drives commands; the slave is the controller.
// With UPCTRL_PERIOD_CNT_EN defined, the bundle also carries the saturating period_cnt status.
interface up_counter_ctrl_if
   import up_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
);

   logic             start;
   logic             stop;
   logic             mode;
   logic [WIDTH-1:0] start_val;
   logic [WIDTH-1:0] end_val;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] count;
`ifdef UPCTRL_PERIOD_CNT_EN
   logic [PERIOD_CNT_W-1:0] period_cnt;

   modport master (
      output start, stop, mode, start_val, end_val,
      input  busy, done, count, period_cnt
   );

   modport slave (
      input  start, stop, mode, start_val, end_val,
      output busy, done, count, period_cnt
   );
`else
   modport master (
      output start, stop, mode, start_val, end_val,
      input  busy, done, count
   );

   modport slave (
      input  start, stop, mode, start_val, end_val,
      output busy, done, count
   );
`endif

endinterface

// File: rtl/up_counter_ctrl_ld.sv
// Loadable wrapping up-counter datapath; load has priority over enable.
module up_counter_ld #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = d_in;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign d_out = cnt_q;

endmodule

// File: rtl/up_counter_ctrl.sv
// Sequencing controller for a loadable up-counter: IDLE -> LOAD -> RUN -> DONE, one-shot or periodic.
// Optional UPCTRL_PERIOD_CNT_EN adds a saturating count of completed passes on bus.period_cnt.
module up_counter_ctrl
   import up_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   up_counter_ctrl_if.slave  bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] start_val_q, start_val_d;
   logic [WIDTH-1:0] end_val_q, end_val_d;
   logic             mode_q, mode_d;

   logic             cnt_load;
   logic             cnt_en;
   logic [WIDTH-1:0] count;
   logic             start_ok;
   logic             match;

   assign start_ok = bus.start && !bus.stop;
   assign match    = (count == end_val_q);

   // stop wins over match and reload; gating load/en keeps count at its stop-cycle value
   always_comb begin
      state_d     = state_q;
      start_val_d = start_val_q;
      end_val_d   = end_val_q;
      mode_d      = mode_q;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_ok) begin
               start_val_d = bus.start_val;
               end_val_d   = bus.end_val;
               mode_d      = bus.mode;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else begin
               cnt_load = 1'b1;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_d = IDLE;
            end else if (match) begin
               state_d = DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            if (!bus.stop && mode_q == MODE_PERIODIC) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: only control and capture registers are reset here; reset is asynchronous so outputs clear without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         start_val_q <= '0;
         end_val_q   <= '0;
         mode_q      <= MODE_ONESHOT;
      end else begin
         state_q     <= state_d;
         start_val_q <= start_val_d;
         end_val_q   <= end_val_d;
         mode_q      <= mode_d;
      end
   end

   up_counter_ld #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk   (clk),
      .rst   (rst),
      .load  (cnt_load),
      .en    (cnt_en),
      .d_in  (start_val_q),
      .d_out (count)
   );

   assign bus.busy  = (state_q != IDLE);
   assign bus.done  = (state_q == DONE);
   assign bus.count = count;

`ifdef UPCTRL_PERIOD_CNT_EN
   logic [PERIOD_CNT_W-1:0] period_cnt_q, period_cnt_d;

   always_comb begin
      period_cnt_d = period_cnt_q;
      if (state_q == IDLE && start_ok) begin
         period_cnt_d = '0;
      end else if (state_q == DONE && period_cnt_q != '1) begin
         period_cnt_d = period_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_cnt_q <= '0;
      end else begin
         period_cnt_q <= period_cnt_d;
      end
   end

   assign bus.period_cnt = period_cnt_q;
`endif

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Directed bench for up_counter_ctrl: stimulus pushes expected done events, a monitor pops and checks them.
module tb_up_counter_ctrl;

   localparam int WIDTH = 4;

   typedef struct {
      int               cycle;
      logic [WIDTH-1:0] count;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t exp_q[$];

   up_counter_ctrl_if #(.WIDTH(WIDTH)) bus ();

   up_counter_ctrl #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic issue(input logic [WIDTH-1:0] sv, input logic [WIDTH-1:0] ev,
                        input logic m, output int c0);
      bus.start     = 1'b1;
      bus.start_val = sv;
      bus.end_val   = ev;
      bus.mode      = m;
      c0            = cyc;
      @(negedge clk);
      bus.start     = 1'b0;
   endtask

   // Monitor: every done pulse must match the oldest expected event.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: done seen at cycle %0d, none expected", cyc);
         end else begin
            e = exp_q.pop_front();
            check("done_cycle", cyc, e.cycle);
            check("done_count", bus.count, e.count);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      logic [WIDTH-1:0] wrap_seq [4];
      wrap_seq = '{4'd14, 4'd15, 4'd0, 4'd1};

      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.mode      = 1'b0;
      bus.start_val = '0;
      bus.end_val   = '0;

      // Reset before any clock edge
      #1 rst = 1'b1;
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_count", bus.count, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", bus.busy, 0);

      // One-shot 3 -> 7
      issue(4'd3, 4'd7, 1'b0, c0);
      exp_q.push_back('{c0 + 7, 4'd7});
      check("os_busy_c1", bus.busy, 1);
      goto(c0 + 2);
      check("os_count_c2", bus.count, 3);
      goto(c0 + 8);
      check("os_busy_c8", bus.busy, 0);
      check("os_count_c8", bus.count, 7);
`ifdef UPCTRL_PERIOD_CNT_EN
      check("os_period_cnt", bus.period_cnt, 1);
`endif
      goto(c0 + 9);
      check("os_count_hold", bus.count, 7);

      // Wrap 14 -> 1
      issue(4'd14, 4'd1, 1'b0, c0);
      exp_q.push_back('{c0 + 6, 4'd1});
      for (int i = 0; i < 4; i++) begin
         goto(c0 + 2 + i);
         check("wrap_count", bus.count, wrap_seq[i]);
      end
      goto(c0 + 7);
      check("wrap_idle", bus.busy, 0);

      // Periodic 0 -> 2, stopped in cycle 12
      issue(4'd0, 4'd2, 1'b1, c0);
      exp_q.push_back('{c0 + 5, 4'd2});
      exp_q.push_back('{c0 + 10, 4'd2});
      goto(c0 + 12);
      check("per_busy_c12", bus.busy, 1);
      check("per_count_c12", bus.count, 0);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      check("per_stop_busy", bus.busy, 0);
      check("per_stop_count", bus.count, 0);
      goto(c0 + 16);
      check("per_idle_c16", bus.busy, 0);
`ifdef UPCTRL_PERIOD_CNT_EN
      check("per_period_cnt", bus.period_cnt, 2);
`endif

      // start while busy is ignored
      issue(4'd3, 4'd9, 1'b0, c0);
      exp_q.push_back('{c0 + 9, 4'd9});
      goto(c0 + 4);
      bus.start     = 1'b1;
      bus.start_val = 4'd12;
      bus.end_val   = 4'd13;
      bus.mode      = 1'b1;
      @(negedge clk);
      bus.start     = 1'b0;
      goto(c0 + 10);
      check("ign_busy", bus.busy, 0);
      check("ign_count", bus.count, 9);

      // stop in RUN at count 5
      issue(4'd3, 4'd9, 1'b0, c0);
      goto(c0 + 4);
      check("stop_count_c4", bus.count, 5);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      check("stop_busy", bus.busy, 0);
      check("stop_count", bus.count, 5);
      goto(c0 + 12);
      check("stop_count_hold", bus.count, 5);

      // Equal values 9 -> 9
      issue(4'd9, 4'd9, 1'b0, c0);
      exp_q.push_back('{c0 + 3, 4'd9});
      goto(c0 + 3);
      check("eq_busy_c3", bus.busy, 1);
      goto(c0 + 4);
      check("eq_busy_c4", bus.busy, 0);
      check("eq_count", bus.count, 9);

      // start and stop together in IDLE
      bus.start     = 1'b1;
      bus.stop      = 1'b1;
      bus.start_val = 4'd1;
      bus.end_val   = 4'd1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("ss_busy", bus.busy, 0);
      @(negedge clk);
      check("ss_busy2", bus.busy, 0);
      check("ss_count", bus.count, 9);

      // Reset asserted mid-RUN at count 5, between edges
      issue(4'd3, 4'd9, 1'b0, c0);
      goto(c0 + 4);
      check("mrst_count_c4", bus.count, 5);
      #2 rst = 1'b1;
      #1;
      check("mrst_busy", bus.busy, 0);
      check("mrst_done", bus.done, 0);
      check("mrst_count", bus.count, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mrst_idle_busy", bus.busy, 0);
      check("mrst_idle_count", bus.count, 0);

      check("pending_done_events", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/up_counter_ctrl.md
Name: up_counter_ctrl

Overview:
- Sequencing controller for a loadable up-counter datapath.
- Accepts a start command with start value, end value and mode.
- Preloads the counter, lets it count up (wrapping modulo 2^WIDTH), and flags the end-value match with a one-cycle done pulse.
- One-shot and periodic (auto-reload) modes.
- Instantiated wherever the design needs a programmable interval or event timer built on the 4-bit up-counter.

Parameters:
- WIDTH, 4, counter and value width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  command strobe; accepted only in IDLE with stop low
- stop  input  1  abort; returns to IDLE from any non-IDLE state
- mode  input  1  0 = one-shot, 1 = periodic; captured on accepted start
- start_val  input  WIDTH  preload value; captured on accepted start
- end_val  input  WIDTH  terminal value; captured on accepted start
- busy  output  1  high in LOAD, RUN and DONE
- done  output  1  one-cycle pulse, high only in the DONE state
- count  output  WIDTH  current counter value

Behaviour:
- Reset (async, immediate): state IDLE, busy=0, done=0, count=0, captured registers=0.
- States:
  - IDLE: start && !stop at an edge captures start_val, end_val and mode, then moves to LOAD.
  - LOAD: lasts exactly 1 cycle; counter load=1 with captured start_val; next state RUN.
  - RUN: counter enabled (+1 per cycle, wraps 2^WIDTH-1 -> 0) while count != end_val. When count == end_val, the counter holds and the next state is DONE.
  - DONE: lasts 1 cycle; done=1. Next state is LOAD if periodic, else IDLE.
- Latency (start sampled at edge of cycle 0):
  - LOAD in cycle 1.
  - count=start_val from cycle 2.
  - done in cycle 2+D+1, where D=(end_val-start_val) mod 2^WIDTH.
  - Periodic period = D+3 cycles.
- Equal values: start_val == end_val gives D=0; done in cycle 3.
- stop:
  - Has priority over match and over the periodic reload.
  - In LOAD, RUN or DONE, the next state is IDLE and no done is issued for that pass.
  - The counter enable is gated by stop, so count holds the value present in the stop cycle.
- start while busy: ignored; captured values are unchanged.
- start and stop together in IDLE: start is not accepted.
- count is not cleared on return to IDLE; it holds until the next LOAD or reset.
- Reset asserted mid-operation: immediate IDLE with count=0. Operation resumes only on a new start after reset deasserts.
- All outputs are registered or decoded from registered state; no combinational path from inputs to busy or done.

Optional Feature:
- Macro: UPCTRL_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt [7:0], counting DONE cycles.
  - Saturates at 255.
  - Cleared to 0 on reset and on accepted start.
  - Unaffected by stop.
- Undefined: port and logic absent; the rest of the behaviour is identical.

Decomposition:
- Shared package up_ctrl_pkg:
  - State encodings IDLE=2'b00, LOAD=2'b01, RUN=2'b10, DONE=2'b11.
  - MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
  - PERIOD_CNT_W=8.
- Sub-module up_counter_ld:
  - Ports: clk, rst (async active-high), load, en, d_in[WIDTH], d_out[WIDTH].
  - Load has priority over en.
  - The controller FSM and capture registers live in up_counter_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles, then rst asserted mid-RUN at count=5 -> busy=0, done=0, count=0 immediately, with no clock edge required.
- One-shot, start_val=3, end_val=7, mode=0:
  - busy high from cycle 1; count=3 in cycle 2.
  - done in cycle 7 only; count=7.
  - IDLE with busy=0 in cycle 8; count stays 7.
- Wrap, start_val=14, end_val=1:
  - count sequence 14, 15, 0, 1 in cycles 2-5.
  - done in cycle 6.
- Periodic, start_val=0, end_val=2, mode=1:
  - done in cycles 5, 10, 15 (period 5).
  - stop in cycle 12 -> IDLE in cycle 13, no done in cycle 15.
  - With UPCTRL_PERIOD_CNT_EN: period_cnt=2.
- Stop and start corner cases:
  - stop asserted in RUN when count=5 (start 3, end 9) -> IDLE next cycle, count holds 5, no done.
  - start with a different start_val pulsed in cycle 4 while busy -> ignored.
- Equal values, start_val=end_val=9 -> done in cycle 3, count=9.
- start and stop both high in IDLE -> remains IDLE, busy=0.
